// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the uart_rx_byte receiver.
//   state_t    - receiver FSM states
//   PARITY_POL - required XOR of the 8 data bits plus the parity bit
//                (0 = even parity)
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  localparam logic PARITY_POL = 1'b0;

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit.
// Both flops reset to RESET_VAL so an idle-high line looks idle out of reset.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output (2 clk of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with mid-bit sampling.
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   ena        - receiver enable; low aborts a frame and holds IDLE
//   rx         - asynchronous serial line, idle high
//   data_out   - last good byte, held until the next good byte
//   data_valid - 1-cycle pulse when data_out updates
//   frame_err  - 1-cycle pulse when the stop bit is sampled low
//   parity_err - 1-cycle pulse on parity mismatch (0 without parity)
//   busy       - high whenever the FSM is not in IDLE
// The FSM state is held in 'state' (type state_t) for hierarchical probing.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  import uart_rx_pkg::*;

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shreg, shreg_nx;
  logic [7:0]       data_out_nx;
  logic             valid_nx, ferr_nx;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_bit_nx;
  logic             perr_nx;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bit_idx    <= bit_idx_nx;
      shreg      <= shreg_nx;
      data_out   <= data_out_nx;
      data_valid <= valid_nx;
      frame_err  <= ferr_nx;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_nx;
      parity_err <= perr_nx;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    data_out_nx = data_out;
    valid_nx    = 1'b0;
    ferr_nx     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nx  = par_bit;
    perr_nx     = 1'b0;
`endif
    if (!ena) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nx = START;
            cnt_nx   = '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_nx = '0;
            // A line that is high again at mid-start was a glitch.
            if (!rx_s) begin
              state_nx   = DATA;
              bit_idx_nx = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_nx     = '0;
            shreg_nx   = {rx_s, shreg[7:1]};  // LSB arrives first
            bit_idx_nx = bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt_nx     = '0;
            par_bit_nx = rx_s;
            state_nx   = STOP;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_nx = '0;
            if (!rx_s) begin
              // Frame error wins over parity; wait for the line to
              // recover so a break cannot look like a new start bit.
              ferr_nx  = 1'b1;
              state_nx = WAIT_HIGH;
            end else begin
              // Leaving at mid-stop leaves half a bit to catch the next start.
              state_nx = IDLE;
`ifdef UART_RX_PARITY_EN
              if ((^{shreg, par_bit}) != PARITY_POL) begin
                perr_nx = 1'b1;
              end else begin
                valid_nx    = 1'b1;
                data_out_nx = shreg;
              end
`else
              valid_nx    = 1'b1;
              data_out_nx = shreg;
`endif
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule
